// File: rtl/alu16_core.sv
// 16-bit four-function ALU: single-cycle add/sub/mul and an iterative
// restoring divider that resolves one quotient bit per clock.
module alu16_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             ov
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    // Handshake: a request is taken on any rising edge with in_valid=1 and
    // busy=0; requests seen while busy=1 are dropped, never queued.
    typedef enum logic {S_IDLE, S_DIV} state_t;

    state_t           state;
    logic             pend;
    logic [WIDTH-1:0] pa, pb;
    logic [1:0]       psel;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic [CW-1:0]    cnt;

    logic             accept, start_div;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] op_res;
    logic             op_ov;
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic             take;
    logic [WIDTH-1:0] rem_next, quo_next;

    assign busy      = (state == S_DIV);
    assign accept    = in_valid && !busy;
    assign start_div = accept && (sel == 2'd3) && (b != '0);

    always_comb begin
        sum    = {1'b0, pa} + {1'b0, pb};
        diff   = pa - pb;
        prod   = {{WIDTH{1'b0}}, pa} * {{WIDTH{1'b0}}, pb};
        op_res = '1;
        op_ov  = 1'b1;
        case (psel)
            OP_ADD: begin
                op_res = sum[WIDTH-1:0];
                op_ov  = sum[WIDTH];
            end
            OP_SUB: begin
                op_res = diff;
                op_ov  = (pa[WIDTH-1] != pb[WIDTH-1]) && (diff[WIDTH-1] != pa[WIDTH-1]);
            end
            OP_MUL: begin
                op_res = prod[WIDTH-1:0];
                op_ov  = |prod[2*WIDTH-1:WIDTH];
            end
            default: begin
                // Only divide-by-zero reaches this path; real divides use the iterator.
                op_res = '1;
                op_ov  = 1'b1;
            end
        endcase
    end

    // Partial remainder stays below the divisor, so a borrow (bit WIDTH set)
    // after the trial subtract means the divisor did not fit.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, dvs};
        take     = ~rem_sub[WIDTH];
        rem_next = take ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], take};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pend      <= 1'b0;
            pa        <= '0;
            pb        <= '0;
            psel      <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            ov        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            pend      <= accept && !start_div;
            if (accept) begin
                pa   <= a;
                pb   <= b;
                psel <= sel;
            end
            if (pend) begin
                result    <= op_res;
                ov        <= op_ov;
                out_valid <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start_div) begin
                        quo   <= a;
                        dvs   <= b;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    quo <= quo_next;
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        result    <= quo_next;
                        ov        <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_core.sv
// Directed testbench for alu16_core: each task drives one scenario and
// compares outputs at the falling edge against hand-computed values.
module tb_alu16_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a, b;
    logic [1:0]  sel;
    logic        busy, out_valid, ov;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;
    logic [16:0] exp_q[$];

    alu16_core #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .sel(sel),
        .busy(busy), .out_valid(out_valid), .result(result), .ov(ov)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver: present one request for exactly one rising edge (edge N)
    task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic [1:0] vs);
        @(negedge clk);
        a = va; b = vb; sel = vs; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // single-cycle op: result due at edge N+1
    task automatic check_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                            input logic [1:0] vs, input logic [15:0] er, input logic eo);
        issue(va, vb, vs);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early_valid: got %b want 0", name, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== er || ov !== eo || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got v=%b r=%h ov=%b busy=%b want v=1 r=%h ov=%b busy=0",
                     name, out_valid, result, ov, busy, er, eo);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 16'h0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL reset: got busy=%b v=%b r=%h ov=%b want all 0", busy, out_valid, result, ov);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        check_op("add_ovf", 16'd62000, 16'd12345, 2'd0, 16'd8809, 1'b1);
        check_op("add_plain", 16'd1000, 16'd2000, 2'd0, 16'd3000, 1'b0);
        // result and ov hold once the pulse is gone
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== 16'd3000 || ov !== 1'b0) begin
            errors++;
            $display("FAIL add_hold: got v=%b r=%h ov=%b want v=0 r=0bb8 ov=0", out_valid, result, ov);
        end
    endtask

    task automatic test_sub();
        check_op("sub_neg_ovf", 16'h8008, 16'd10, 2'd1, 16'h7FFE, 1'b1);
        check_op("sub_pos_ovf", 16'd32760, 16'hFEE8, 2'd1, 16'h8110, 1'b1);
        check_op("sub_plain", 16'd100, 16'd300, 2'd1, 16'hFF38, 1'b0);
    endtask

    task automatic test_mul();
        check_op("mul_ovf", 16'd800, 16'd1000, 2'd2, 16'h3500, 1'b1);
        check_op("mul_wrap0", 16'd32768, 16'd2, 2'd2, 16'h0000, 1'b1);
        check_op("mul_plain", 16'd100, 16'd200, 2'd2, 16'd20000, 1'b0);
    endtask

    task automatic test_div_zero();
        check_op("div_zero", 16'd5324, 16'd0, 2'd3, 16'hFFFF, 1'b1);
    endtask

    task automatic test_div();
        int  cyc;
        bit  seen;
        bit  busy_gap;
        issue(16'd30000, 16'd7, 2'd3);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL div_start: got busy=%b v=%b want busy=1 v=0", busy, out_valid);
        end
        cyc = 0; seen = 0; busy_gap = 0;
        while (!seen && cyc < 40) begin
            // stray requests at edges N+3 and N+16 must be dropped
            if (cyc == 2 || cyc == 15) begin
                a = 16'd1; b = 16'd1; sel = 2'd0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (out_valid) seen = 1;
            else if (!busy) busy_gap = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc !== 16 || busy_gap) begin
            errors++;
            $display("FAIL div_latency: got %0d cycles gap=%b want 16 gap=0", cyc, busy_gap);
        end
        checks++;
        if (result !== 16'd4285 || ov !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL div_result: got r=%0d ov=%b busy=%b want r=4285 ov=0 busy=0", result, ov, busy);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'd4285) begin
            errors++;
            $display("FAIL div_dropped: got v=%b busy=%b r=%0d want v=0 busy=0 r=4285", out_valid, busy, result);
        end
    endtask

    task automatic test_reset_mid_div();
        int extra;
        issue(16'd30000, 16'd7, 2'd3);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 16'h0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_div: got busy=%b v=%b r=%h ov=%b want all 0", busy, out_valid, result, ov);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL reset_abort: got %0d stray pulses want 0", extra);
        end
        check_op("after_reset_add", 16'd1000, 16'd2000, 2'd0, 16'd3000, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] va[4] = '{16'd1000, 16'h8008, 16'd100, 16'd5324};
        logic [15:0] vb[4] = '{16'd2000, 16'd10,   16'd200, 16'd0};
        logic [1:0]  vs[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [16:0] ev[4] = '{{1'b0, 16'd3000}, {1'b1, 16'h7FFE}, {1'b0, 16'd20000}, {1'b1, 16'hFFFF}};
        logic [16:0] exp_v;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                a = va[i]; b = vb[i]; sel = vs[i]; in_valid = 1'b1;
                exp_q.push_back(ev[i]);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (i > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || {ov, result} !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_%0d: got v=%b ov=%b r=%h want v=1 ov=%b r=%h",
                             i - 1, out_valid, ov, result, exp_v[16], exp_v[15:0]);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div_zero();
        test_div();
        test_reset_mid_div();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu16_core.md
Name: alu16_core

Overview:
- 16-bit four-function integer ALU: unsigned add, signed subtract, unsigned multiply, unsigned divide.
- Each result carries an overflow/exception flag.
- Operands and opcode are captured on a valid strobe. Add/sub/mul complete in one cycle; divide is iterative, one quotient bit per cycle.
- Sits behind a simple valid/busy handshake as a datapath helper block.

Parameters:
- WIDTH, 16, operand/result width. Only 16 is required to be supported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request strobe; accepted when busy=0
- a  input  16  operand A
- b  input  16  operand B
- sel  input  2  opcode: 0 add, 1 sub, 2 mul, 3 div
- busy  output  1  divide in progress; requests ignored while high
- out_valid  output  1  one-cycle pulse when result/ov are updated
- result  output  16  operation result
- ov  output  1  overflow / divide-by-zero flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - busy=0, out_valid=0, result=0, ov=0.
  - Any divide in progress is aborted; no out_valid is produced for it.
- Acceptance: at a rising edge where in_valid=1 and busy=0, a, b and sel are captured. Call this edge N.
  - in_valid while busy=1 is dropped silently; no queueing.
  - Operand changes after acceptance have no effect.
- sel=0, unsigned add:
  - result = (a+b)[15:0]; ov = carry out of bit 15.
  - Registered at edge N+1 with out_valid=1.
- sel=1, two's-complement subtract:
  - result = (a-b)[15:0].
  - ov = signed overflow: a[15]!=b[15] and result[15]!=a[15].
  - Registered at edge N+1.
- sel=2, unsigned multiply:
  - 32-bit product P = a*b; result = P[15:0]; ov = (P[31:16]!=0).
  - Registered at edge N+1.
- sel=3, unsigned divide:
  - b=0: result=16'hFFFF, ov=1, out_valid at edge N+1; busy never asserts.
  - b!=0: restoring shift/subtract divider.
    - busy=1 from after edge N; one quotient bit is resolved per edge, N+1 through N+16.
    - At edge N+16: result = floor(a/b), ov=0, out_valid=1, busy=0.
    - A new request can therefore be accepted at edge N+17 at the earliest; in_valid sampled at edge N+16 itself is ignored because busy is still 1 at that edge.
    - The remainder is computed internally and not exported.
- out_valid is high for exactly one cycle per completed operation and is 0 otherwise.
- result and ov hold their last value between completions.
- Back-to-back single-cycle ops: a request accepted on every edge yields out_valid on every following edge.

Test Plan:
- Add overflow: sel=0, a=62000, b=12345 -> one cycle later result=8809, ov=1, out_valid pulse. a=1000, b=2000 -> result=3000, ov=0.
- Signed sub overflow:
  - sel=1, a=16'h8008 (-32760), b=10 -> result=16'h7FFE, ov=1.
  - a=32760, b=16'hFEE8 (-280) -> result=16'h8110, ov=1.
  - a=100, b=300 -> result=16'hFF38, ov=0.
- Multiply:
  - sel=2, a=800, b=1000 -> result=16'h3500, ov=1.
  - a=32768, b=2 -> result=0, ov=1.
  - a=100, b=200 -> result=20000, ov=0.
- Divide:
  - sel=3, a=30000, b=7 -> busy high for 16 cycles, then result=4285, ov=0 with out_valid at edge N+16.
  - A request presented during busy is ignored (no extra out_valid).
- Divide by zero: sel=3, a=5324, b=0 -> result=16'hFFFF, ov=1 at edge N+1; busy stays 0.
- Reset mid-divide: assert rst_n=0 at cycle 8 of a divide -> busy, out_valid, result, ov all 0 immediately. After release, the next request behaves normally.
